// File: rtl/drysponge_pkg.sv
// drysponge_pkg: shared mix-engine FSM encoding and GASCON round helpers -- rev 1.0
`default_nettype none

package drysponge_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MIX_START = 3'd1,
    MIX_WAIT  = 3'd2,
    GAS_START = 3'd3,
    GAS_WAIT  = 3'd4,
    FINISH    = 3'd5
  } mix_state_t;

  function automatic int steps_f(input int total, input int dwidth);
    return (total + dwidth - 1) / dwidth;
  endfunction

  function automatic logic [63:0] rotr64_f(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Two rotation amounts per 64-bit lane of the linear diffusion layer.
  function automatic int rot_amt_f(input int w, input int k);
    case (w)
      0:       return (k == 0) ? 19 : 28;
      1:       return (k == 0) ? 61 : 39;
      2:       return (k == 0) ? 1  : 6;
      3:       return (k == 0) ? 10 : 17;
      4:       return (k == 0) ? 7  : 41;
      5:       return (k == 0) ? 31 : 26;
      6:       return (k == 0) ? 53 : 58;
      7:       return (k == 0) ? 9  : 46;
      default: return (k == 0) ? 43 : 50;
    endcase
  endfunction

  function automatic logic [7:0] round_const_f(input int r);
    return 8'(((15 - r) << 4) | r);
  endfunction

endpackage

`default_nettype wire

// File: rtl/Gascon_Core_Round.sv
// Gascon_Core_Round: ROUND_COUNT GASCON permutation rounds on C, one per cycle; reset loads c_in -- rev 1.0
`default_nettype none

module Gascon_Core_Round
  import drysponge_pkg::*;
#(
  parameter  int CWORDS64    = 5,
  parameter  int ROUND_COUNT = 1,
  localparam int CWIDTH      = CWORDS64 * 64,
  localparam int MID         = CWORDS64 / 2,
  localparam int CNT_W       = $clog2(ROUND_COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CWIDTH-1:0] c_in,
  output logic              done,
  output logic [CWIDTH-1:0] gas_out
);

  logic [CWIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  function automatic logic [CWIDTH-1:0] round_f(input logic [CWIDTH-1:0] c, input logic [7:0] rc);
    logic [63:0] x [CWORDS64];
    logic [63:0] t [CWORDS64];
    logic [CWIDTH-1:0] r;
    for (int i = 0; i < CWORDS64; i++) x[i] = c[i*64 +: 64];
    x[MID] = x[MID] ^ {56'd0, rc};
    // Generalised 5-bit-style sbox over an odd number of lanes.
    for (int i = 0; i <= MID; i++) x[2*i] = x[2*i] ^ x[(2*i + CWORDS64 - 1) % CWORDS64];
    for (int i = 0; i < CWORDS64; i++) t[i] = ~x[i] & x[(i + 1) % CWORDS64];
    for (int i = 0; i < CWORDS64; i++) x[i] = x[i] ^ t[(i + 1) % CWORDS64];
    for (int i = 0; i <= MID; i++) x[(2*i + 1) % CWORDS64] = x[(2*i + 1) % CWORDS64] ^ x[2*i];
    x[MID] = ~x[MID];
    for (int i = 0; i < CWORDS64; i++)
      x[i] = x[i] ^ rotr64_f(x[i], rot_amt_f(i, 0)) ^ rotr64_f(x[i], rot_amt_f(i, 1));
    r = '0;
    for (int i = 0; i < CWORDS64; i++) r[i*64 +: 64] = x[i];
    return r;
  endfunction

  always_comb begin
    s_d    = s_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (!done_q) begin
      s_d    = round_f(s_q, round_const_f(int'(cnt_q)));
      cnt_d  = cnt_q + 1'b1;
      done_d = (cnt_q == CNT_W'(ROUND_COUNT - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= c_in;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done    = done_q;
  assign gas_out = s_q;

endmodule

`default_nettype wire

// File: rtl/drysponge_mix_sel.sv
// drysponge_mix_sel: zero-pads the operand vector and picks the DWIDTH slice for step j -- rev 1.0
`default_nettype none

module drysponge_mix_sel
  import drysponge_pkg::*;
#(
  parameter int TOTAL  = 132,
  parameter int DWIDTH = 10,
  parameter int STEPS  = 14,
  parameter int J_W    = 4
) (
  input  logic [TOTAL-1:0]  v,
  input  logic [J_W-1:0]    j,
  output logic [DWIDTH-1:0] d
);

  logic [STEPS*DWIDTH-1:0] v_pad;

  always_comb begin
    v_pad = '0;
    v_pad[TOTAL-1:0] = v;
    d = '0;
    for (int s = 0; s < STEPS; s++) begin
      if (j == J_W'(s)) d = v_pad[s*DWIDTH +: DWIDTH];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mixsx32.sv
// mixsx32: XORs a selector-chosen X word into the low half of every C lane; reset acts as start -- rev 1.0
`default_nettype none

module mixsx32 #(
  parameter  int CWORDS64 = 5,
  parameter  int XWORDS32 = 4,
  localparam int IDX_W    = $clog2(XWORDS32),
  localparam int DWIDTH   = CWORDS64 * IDX_W,
  localparam int CWIDTH   = CWORDS64 * 64,
  localparam int XWIDTH   = XWORDS32 * 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CWIDTH-1:0] c_in,
  input  logic [XWIDTH-1:0] x_in,
  input  logic [DWIDTH-1:0] d_in,
  output logic              data_rdy,
  output logic [CWIDTH-1:0] mix_out
);

  logic [CWIDTH-1:0] out_q, out_d;
  logic              rdy_q, rdy_d;
  logic [CWIDTH-1:0] mixed;

  always_comb begin
    mixed = c_in;
    for (int w = 0; w < CWORDS64; w++) begin
      for (int k = 0; k < XWORDS32; k++) begin
        if (d_in[w*IDX_W +: IDX_W] == IDX_W'(k))
          mixed[w*64 +: 32] = c_in[w*64 +: 32] ^ x_in[k*32 +: 32];
      end
    end
  end

  always_comb begin
    out_d = out_q;
    rdy_d = rdy_q;
    if (!rdy_q) begin
      out_d = mixed;
      rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      out_q <= out_d;
      rdy_q <= rdy_d;
    end
  end

  assign data_rdy = rdy_q;
  assign mix_out  = out_q;

endmodule

`default_nettype wire

// File: rtl/drysponge_mix_engine.sv
// drysponge_mix_engine: DryGASCON mix phase, STEPS mix steps interleaved with STEPS-1 GASCON rounds -- rev 1.0
`default_nettype none

module drysponge_mix_engine
  import drysponge_pkg::*;
#(
  parameter  int CWORDS64 = 5,
  parameter  int XWORDS32 = 4,
  parameter  int IN_WIDTH = 128,
  parameter  int DS_WIDTH = 4,
  localparam int CWIDTH   = CWORDS64 * 64,
  localparam int XWIDTH   = XWORDS32 * 32,
  localparam int IDX_W    = $clog2(XWORDS32),
  localparam int DWIDTH   = CWORDS64 * IDX_W,
  localparam int TOTAL    = IN_WIDTH + DS_WIDTH,
  localparam int STEPS    = steps_f(TOTAL, DWIDTH),
  localparam int J_W      = $clog2(STEPS + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CWIDTH-1:0]   c_in,
  input  logic [XWIDTH-1:0]   x_in,
  input  logic [IN_WIDTH-1:0] i_in,
  input  logic [DS_WIDTH-1:0] ds_in,
  output logic                busy,
  output logic                done,
  output logic [CWIDTH-1:0]   c_out,
  output logic [J_W-1:0]      step_idx
);

  if ((XWORDS32 < 2) || ((XWORDS32 & (XWORDS32 - 1)) != 0)) begin : g_bad_xwords
    $error("XWORDS32 must be a power of 2 and at least 2");
  end
  if ((IN_WIDTH != 128) && (IN_WIDTH != 256)) begin : g_bad_in_width
    $error("IN_WIDTH must be 128 or 256");
  end

  mix_state_t        state_q, state_d;
  logic [J_W-1:0]    j_q, j_d;
  logic [CWIDTH-1:0] c_q, c_d;
  logic [XWIDTH-1:0] x_q, x_d;
  logic [TOTAL-1:0]  v_q, v_d;
  logic [DWIDTH-1:0] sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CWIDTH-1:0] c_out_q, c_out_d;

  logic [DWIDTH-1:0] sel_w;
  logic              mix_start, gas_start, mix_rst, gas_rst;
  logic              mix_rdy, gas_done;
  logic [CWIDTH-1:0] mix_out, gas_out;

  assign mix_start = (state_q == MIX_START);
  assign gas_start = (state_q == GAS_START);
  assign mix_rst   = ~reset_n | mix_start;
  assign gas_rst   = ~reset_n | gas_start;

  drysponge_mix_sel #(
    .TOTAL  (TOTAL),
    .DWIDTH (DWIDTH),
    .STEPS  (STEPS),
    .J_W    (J_W)
  ) u_sel (
    .v (v_q),
    .j (j_q),
    .d (sel_w)
  );

  mixsx32 #(
    .CWORDS64 (CWORDS64),
    .XWORDS32 (XWORDS32)
  ) u_mix (
    .clk      (clk),
    .rst      (mix_rst),
    .c_in     (c_q),
    .x_in     (x_q),
    .d_in     (sel_q),
    .data_rdy (mix_rdy),
    .mix_out  (mix_out)
  );

  Gascon_Core_Round #(
    .CWORDS64    (CWORDS64),
    .ROUND_COUNT (1)
  ) u_gas (
    .clk     (clk),
    .rst     (gas_rst),
    .c_in    (c_q),
    .done    (gas_done),
    .gas_out (gas_out)
  );

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    c_d     = c_q;
    x_d     = x_q;
    v_d     = v_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    c_out_d = c_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          c_d     = c_in;
          x_d     = x_in;
          v_d     = {ds_in, i_in};
          j_d     = '0;
          busy_d  = 1'b1;
          state_d = MIX_START;
        end
      end
      MIX_START: begin
        sel_d   = sel_w;
        state_d = MIX_WAIT;
      end
      MIX_WAIT: begin
        if (mix_rdy) begin
          c_d = mix_out;
          // Last step is mix-only: publish the result so done and c_out align.
          if (j_q == J_W'(STEPS - 1)) begin
            c_out_d = mix_out;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FINISH;
          end else begin
            state_d = GAS_START;
          end
        end
      end
      GAS_START: state_d = GAS_WAIT;
      GAS_WAIT: begin
        if (gas_done) begin
          c_d     = gas_out;
          j_d     = j_q + 1'b1;
          state_d = MIX_START;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      j_q     <= '0;
      c_q     <= '0;
      x_q     <= '0;
      v_q     <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_out_q <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      c_q     <= c_d;
      x_q     <= x_d;
      v_q     <= v_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_out_q <= c_out_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign c_out    = c_out_q;
  assign step_idx = j_q;

endmodule

`default_nettype wire

// File: tb/tb_drysponge_mix_engine.sv
// tb_drysponge_mix_engine: directed scenario tasks against an independent DryGASCON mix model -- rev 1.0
`default_nettype none

module tb_drysponge_mix_engine;

  logic         clk;
  logic         reset_n;
  logic         start, start2;
  logic [319:0] c_in;
  logic [127:0] x_in;
  logic [127:0] i_in;
  logic [255:0] i2_in;
  logic [3:0]   ds_in, ds2_in;
  logic         busy, done, busy2, done2;
  logic [319:0] c_out, c_out2;
  logic [3:0]   step_idx;
  logic [4:0]   step_idx2;

  int n_checks = 0;
  int n_fail   = 0;
  int mix_cnt = 0, gas_cnt = 0, done_cnt = 0;
  int mix_cnt2 = 0, gas_cnt2 = 0;

  logic [319:0] c_pat;
  logic [127:0] x_pat, i_pat;
  logic [319:0] exp_g, exp_b, exp_256;

  drysponge_mix_engine #(
    .CWORDS64 (5), .XWORDS32 (4), .IN_WIDTH (128), .DS_WIDTH (4)
  ) dut (
    .clk (clk), .reset_n (reset_n), .start (start),
    .c_in (c_in), .x_in (x_in), .i_in (i_in), .ds_in (ds_in),
    .busy (busy), .done (done), .c_out (c_out), .step_idx (step_idx)
  );

  drysponge_mix_engine #(
    .CWORDS64 (5), .XWORDS32 (4), .IN_WIDTH (256), .DS_WIDTH (4)
  ) dut256 (
    .clk (clk), .reset_n (reset_n), .start (start2),
    .c_in (c_in), .x_in (x_in), .i_in (i2_in), .ds_in (ds2_in),
    .busy (busy2), .done (done2), .c_out (c_out2), .step_idx (step_idx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dut.mix_start) mix_cnt++;
    if (dut.gas_start) gas_cnt++;
    if (done) done_cnt++;
    if (dut256.mix_start) mix_cnt2++;
    if (dut256.gas_start) gas_cnt2++;
  end

  function automatic logic [63:0] rr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] gascon_m(input logic [319:0] c);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x4, x3, x2, x1, x0} = c;
    x2 = x2 ^ 64'hF0;
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ rr(x0, 19) ^ rr(x0, 28);
    x1 = x1 ^ rr(x1, 61) ^ rr(x1, 39);
    x2 = x2 ^ rr(x2, 1)  ^ rr(x2, 6);
    x3 = x3 ^ rr(x3, 10) ^ rr(x3, 17);
    x4 = x4 ^ rr(x4, 7)  ^ rr(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  function automatic logic [319:0] model_op(input logic [319:0] c, input logic [127:0] x,
                                            input logic [259:0] v, input int steps);
    logic [319:0] s;
    s = c;
    for (int j = 0; j < steps; j++) begin
      for (int w = 0; w < 5; w++) begin
        int idx;
        idx = int'(v[j*10 + w*2 +: 2]);
        s[w*64 +: 32] = s[w*64 +: 32] ^ x[idx*32 +: 32];
      end
      if (j != steps - 1) s = gascon_m(s);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_golden();
    c_in  = c_pat;
    x_in  = x_pat;
    i_in  = i_pat;
    ds_in = 4'h2;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b1;
    start2  = 1'b1;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (c_out !== 320'd0) begin n_fail++; $display("FAIL reset_c_out: got %h expected 0", c_out); end
    n_checks++; if (step_idx !== 4'd0) begin n_fail++; $display("FAIL reset_step_idx: got %0d expected 0", step_idx); end
    n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy256: got %b expected 0", busy2); end
    start   = 1'b0;
    start2  = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_golden();
    bit ok;
    int d0, m0, g0;
    d0 = done_cnt; m0 = mix_cnt; g0 = gas_cnt;
    drive_golden();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL golden_busy: got %b expected 1", busy); end
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL golden_timeout: done=%b expected 1", done); end
    n_checks++; if (c_out !== exp_g) begin n_fail++; $display("FAIL golden_c_out: got %h expected %h", c_out, exp_g); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL golden_busy_at_done: got %b expected 0", busy); end
    repeat (5) tick();
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL golden_done_count: got %0d expected 1", done_cnt - d0); end
    n_checks++; if (mix_cnt - m0 != 14) begin n_fail++; $display("FAIL golden_mix_starts: got %0d expected 14", mix_cnt - m0); end
    n_checks++; if (gas_cnt - g0 != 13) begin n_fail++; $display("FAIL golden_gas_starts: got %0d expected 13", gas_cnt - g0); end
    n_checks++; if (c_out !== exp_g) begin n_fail++; $display("FAIL golden_c_out_held: got %h expected %h", c_out, exp_g); end
  endtask

  task automatic test_start_while_busy();
    bit ok, dropped;
    ok = 1'b0; dropped = 1'b0;
    drive_golden();
    start = 1'b1;
    tick();
    for (int i = 0; i < 400 && !ok; i++) begin
      for (int k = 0; k < 10; k++) c_in[k*32 +: 32] = $urandom;
      for (int k = 0; k < 4; k++) begin
        x_in[k*32 +: 32] = $urandom;
        i_in[k*32 +: 32] = $urandom;
      end
      ds_in = 4'($urandom);
      tick();
      if (done) ok = 1'b1;
      else if (!busy) dropped = 1'b1;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL busy_timeout: done=%b expected 1", done); end
    n_checks++; if (dropped) begin n_fail++; $display("FAIL busy_dropped: got 1 expected 0"); end
    n_checks++; if (c_out !== exp_g) begin n_fail++; $display("FAIL busy_c_out: got %h expected %h", c_out, exp_g); end
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done_cycle: busy got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    ok = 1'b0;
    drive_golden();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (step_idx == 4'd7) ok = 1'b1;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL midreset_reach_j7: step_idx=%0d expected 7", step_idx); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
    n_checks++; if (c_out !== 320'd0) begin n_fail++; $display("FAIL midreset_c_out: got %h expected 0", c_out); end
    n_checks++; if (step_idx !== 4'd0) begin n_fail++; $display("FAIL midreset_step_idx: got %0d expected 0", step_idx); end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL midreset_timeout: done=%b expected 1", done); end
    n_checks++; if (c_out !== exp_g) begin n_fail++; $display("FAIL midreset_c_out_after: got %h expected %h", c_out, exp_g); end
  endtask

  task automatic test_back_to_back();
    bit ok, held_bad;
    int d0;
    held_bad = 1'b0;
    d0 = done_cnt;
    drive_golden();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(ok);
    n_checks++; if (c_out !== exp_g) begin n_fail++; $display("FAIL b2b_first_c_out: got %h expected %h", c_out, exp_g); end
    i_in  = ~i_pat;
    ds_in = 4'h9;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy got %b expected 1", busy); end
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (done) ok = 1'b1;
      else if (c_out !== exp_g) held_bad = 1'b1;
    end
    n_checks++; if (held_bad) begin n_fail++; $display("FAIL b2b_c_out_held: got changed expected held"); end
    n_checks++; if (c_out !== exp_b) begin n_fail++; $display("FAIL b2b_second_c_out: got %h expected %h", c_out, exp_b); end
    tick();
    n_checks++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
  endtask

  task automatic test_in256();
    bit ok;
    int m0, g0;
    ok = 1'b0;
    m0 = mix_cnt2; g0 = gas_cnt2;
    c_in   = c_pat;
    x_in   = x_pat;
    i2_in  = '1;
    ds2_in = 4'hF;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      tick();
      if (done2) ok = 1'b1;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL in256_timeout: done=%b expected 1", done2); end
    n_checks++; if (c_out2 !== exp_256) begin n_fail++; $display("FAIL in256_c_out: got %h expected %h", c_out2, exp_256); end
    tick();
    n_checks++; if (mix_cnt2 - m0 != 26) begin n_fail++; $display("FAIL in256_mix_starts: got %0d expected 26", mix_cnt2 - m0); end
    n_checks++; if (gas_cnt2 - g0 != 25) begin n_fail++; $display("FAIL in256_gas_starts: got %0d expected 25", gas_cnt2 - g0); end
  endtask

  initial begin
    logic [259:0] v;
    reset_n = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    c_in    = '0;
    x_in    = '0;
    i_in    = '0;
    i2_in   = '0;
    ds_in   = '0;
    ds2_in  = '0;
    for (int k = 0; k < 40; k++) c_pat[k*8 +: 8] = 8'(k % 16);
    for (int k = 0; k < 16; k++) begin
      x_pat[k*8 +: 8] = 8'(k);
      i_pat[k*8 +: 8] = 8'(k);
    end
    v = '0; v[131:0] = {4'h2, i_pat};
    exp_g = model_op(c_pat, x_pat, v, 14);
    v = '0; v[131:0] = {4'h9, ~i_pat};
    exp_b = model_op(c_pat, x_pat, v, 14);
    v = {4'hF, {256{1'b1}}};
    exp_256 = model_op(c_pat, x_pat, v, 26);

    test_reset();
    test_golden();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_in256();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
